// File: rtl/pc_unit_ras.sv
// Program counter with sequential, branch, jump, jump-register and call/return sources.
// The return-address stack is a circular buffer; a push while full overwrites the oldest entry.
module pc_unit_ras #(
    parameter int W         = 6,
    parameter int RAS_DEPTH = 4,
    parameter int STEP      = 1
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         stall,
    input  logic                         branch,
    input  logic [W-1:0]                 branch_off,
    input  logic                         jump,
    input  logic [W-1:0]                 jump_tgt,
    input  logic                         jr,
    input  logic [W-1:0]                 reg_tgt,
    input  logic                         call,
    input  logic                         ret,
    output logic [W-1:0]                 pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [W-1:0]  STEP_W   = W'(STEP);
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);
    localparam logic [PW-1:0] SP_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [W-1:0]  pc_q, pc_d;
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [W-1:0]  ras_q [RAS_DEPTH];

    logic          push;
    logic [W-1:0]  pc_seq;
    logic [PW-1:0] top_idx;

    assign pc_seq  = pc_q + STEP_W;
    // sp_q points at the next free slot, so the most recent entry sits just below it
    assign top_idx = sp_q - SP_ONE;

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_q[top_idx];
                    sp_d  = top_idx;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    pc_d  = pc_seq;
                    unf_d = 1'b1;
                end
            end else if (jr) begin
                pc_d = reg_tgt;
                push = call;
            end else if (jump) begin
                pc_d = jump_tgt;
                push = call;
            end else if (branch) begin
                pc_d = pc_seq + branch_off;
            end else begin
                pc_d = pc_seq;
            end

            if (push) begin
                sp_d = sp_q + SP_ONE;
                if (cnt_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q  <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents need no reset; only pointer and count define validity
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            ras_q[sp_q] <= pc_seq;
        end
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based model of the PC and return-address stack.
module tb_pc_unit_ras;

    localparam int W         = 6;
    localparam int RAS_DEPTH = 4;
    localparam int STEP      = 1;
    localparam int MODV      = 1 << W;

    logic         clk = 1'b0;
    logic         clr, stall, branch, jump, jr, call, ret;
    logic [W-1:0] branch_off, jump_tgt, reg_tgt;
    logic [W-1:0] pc;
    logic [2:0]   ras_count;
    logic         ras_empty, ras_full, ras_ovf, ras_unf;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_pc;
    int m_q[$];
    bit m_ovf, m_unf;

    pc_unit_ras #(.W(W), .RAS_DEPTH(RAS_DEPTH), .STEP(STEP)) dut (
        .clk(clk), .clr(clr), .stall(stall), .branch(branch), .branch_off(branch_off),
        .jump(jump), .jump_tgt(jump_tgt), .jr(jr), .reg_tgt(reg_tgt),
        .call(call), .ret(ret), .pc(pc), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input int v);
        return ((v % MODV) + MODV) % MODV;
    endfunction

    task automatic idle_inputs();
        clr = 0; stall = 0; branch = 0; jump = 0; jr = 0; call = 0; ret = 0;
        branch_off = '0; jump_tgt = '0; reg_tgt = '0;
    endtask

    task automatic model_step();
        int seq;
        int soff;
        seq  = wrap(m_pc + STEP);
        soff = (int'(branch_off) >= MODV / 2) ? int'(branch_off) - MODV : int'(branch_off);
        if (clr) begin
            m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
        end else if (!stall) begin
            if (ret) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else begin
                    m_pc  = seq;
                    m_unf = 1;
                end
            end else if (jr || jump) begin
                m_pc = jr ? int'(reg_tgt) : int'(jump_tgt);
                if (call) begin
                    m_q.push_back(seq);
                    if (m_q.size() > RAS_DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1;
                    end
                end
            end else if (branch) begin
                m_pc = wrap(m_pc + STEP + soff);
            end else begin
                m_pc = seq;
            end
        end
    endtask

    task automatic cmp(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".pc"},    int'(pc),        m_pc);
        cmp({tag, ".count"}, int'(ras_count), m_q.size());
        cmp({tag, ".empty"}, int'(ras_empty), int'(m_q.size() == 0));
        cmp({tag, ".full"},  int'(ras_full),  int'(m_q.size() == RAS_DEPTH));
        cmp({tag, ".ovf"},   int'(ras_ovf),   int'(m_ovf));
        cmp({tag, ".unf"},   int'(ras_unf),   int'(m_unf));
    endtask

    // Apply the currently driven inputs for one clock and check against the model
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    task automatic go_to(input int tgt);
        jump = 1; jump_tgt = W'(tgt);
        tick("goto");
    endtask

    initial begin
        idle_inputs();
        m_pc = 0; m_ovf = 0; m_unf = 0;
        #2;

        // 1: reset then free-running
        clr = 1; tick("t1_clr0");
        clr = 1; tick("t1_clr1");
        cmp("t1_reset_pc", int'(pc), 0);
        for (int i = 0; i < 3; i++) tick("t1_seq");
        cmp("t1_seq_pc", int'(pc), 3);

        // 2: negative branch and wrap-around
        go_to(10);
        branch = 1; branch_off = 6'h3C; tick("t2_branch");
        cmp("t2_branch_pc", int'(pc), 7);
        go_to(62);
        tick("t2_seq63");
        tick("t2_wrap");
        cmp("t2_wrap_pc", int'(pc), 0);

        // 3: call then return
        go_to(5);
        jump = 1; jump_tgt = 6'd40; call = 1; tick("t3_call");
        cmp("t3_call_cnt", int'(ras_count), 1);
        for (int i = 0; i < 4; i++) tick("t3_seq");
        ret = 1; tick("t3_ret");
        cmp("t3_ret_pc", int'(pc), 6);

        // 4: overflow then underflow
        go_to(1);
        for (int i = 2; i <= 6; i++) begin
            jump = 1; jump_tgt = W'(i); call = 1; tick("t4_call");
        end
        cmp("t4_ovf", int'(ras_ovf), 1);
        cmp("t4_cnt", int'(ras_count), 4);
        for (int i = 0; i < 4; i++) begin
            ret = 1; tick("t4_ret");
            cmp("t4_ret_pc", int'(pc), 6 - i);
        end
        ret = 1; tick("t4_unf");
        cmp("t4_unf_pc", int'(pc), 4);
        cmp("t4_unf_flag", int'(ras_unf), 1);

        // 5: stall holds everything
        go_to(9);
        stall = 1; jump = 1; jump_tgt = 6'd20; call = 1; tick("t5_stall");
        cmp("t5_stall_pc", int'(pc), 9);
        jump = 1; jump_tgt = 6'd20; tick("t5_release");
        cmp("t5_release_pc", int'(pc), 20);

        // 6: ret beats jr+call; clr beats a call
        go_to(11);
        jump = 1; jump_tgt = 6'd30; call = 1; tick("t6_push12");
        ret = 1; jr = 1; reg_tgt = 6'd50; call = 1; tick("t6_ret_jr");
        cmp("t6_ret_pc", int'(pc), 12);
        cmp("t6_no_push", int'(ras_count), 0);
        jump = 1; jump_tgt = 6'd33; call = 1; tick("t6_call");
        clr = 1; jump = 1; jump_tgt = 6'd44; call = 1; tick("t6_clr");
        cmp("t6_clr_pc", int'(pc), 0);
        cmp("t6_clr_cnt", int'(ras_count), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            clr        = ($urandom_range(0, 99) == 0);
            stall      = ($urandom_range(0, 7) == 0);
            ret        = ($urandom_range(0, 5) == 0);
            jr         = ($urandom_range(0, 7) == 0);
            jump       = ($urandom_range(0, 5) == 0);
            branch     = ($urandom_range(0, 3) == 0);
            call       = ($urandom_range(0, 1) == 0);
            branch_off = W'($urandom);
            jump_tgt   = W'($urandom);
            reg_tgt    = W'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
